aq_f_spsram_bist_ctrl: RTL and testbench
========================================

# aq_f_spsram_bist_ctrl

March-test initiator for the 64x58 single-port SRAM macro wrappers in the C906 ASIC memory set. It sits between the functional SRAM requester and the SRAM wrapper. In functional mode it passes all SRAM signals straight through. On request it takes over the SRAM port and runs a four-element march test, then reports pass/fail and, optionally, first-failure diagnostics.

## Interface
Parameters:
- ADDR_WIDTH, 6, SRAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 58, SRAM data width.
- BIST_PATTERN, {29{2'b01}}, background pattern P (DATA_WIDTH bits).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- bist_start  in  1  single-cycle start request.
- bist_busy  out  1  march in progress; BIST owns the SRAM.
- bist_done  out  1  sticky completion flag.
- bist_fail  out  1  sticky mismatch flag.
- bist_fail_addr  out  ADDR_WIDTH  first failing address (diag only).
- bist_fail_elem  out  2  march element of the first failure (diag only).
- bist_fail_syn  out  DATA_WIDTH  XOR of expected and read data at the first failure (diag only).
- func_a, func_cen, func_gwen, func_wen, func_d  in  ADDR_WIDTH/1/1/DATA_WIDTH/DATA_WIDTH  functional request.
- func_q  out  DATA_WIDTH  equals sram_q at all times.
- sram_a, sram_cen, sram_gwen, sram_wen, sram_d  out  same widths  to the SRAM wrapper.
  - CEN is active low.
  - GWEN=1 means write.
  - WEN is the active-high bit write enable.
- sram_q  in  DATA_WIDTH  SRAM read data; valid in the cycle after a read access.

## Operation
- State machine: IDLE, M0, M1, M2, M3, DRAIN, DONE.
- Each march state drives sram_cen=0 and sram_wen=all-ones.
- **IDLE/DONE**: sram_* = func_* combinationally (pass-through); bist_busy=0.
- bist_start sampled in IDLE or DONE has the following effect:
  - clears done and fail, plus the diag registers;
  - sets addr=0;
  - moves to M0.
- bist_start is ignored in all other states.
- **M0** (ascending): write P to each address, 1 cycle/addr.
- **M1** (ascending): 2 cycles/addr.
  - Phase 0: read addr.
  - Phase 1: write ~P to addr, and compare sram_q against P.
- **M2** (descending, starts at 2^ADDR_WIDTH-1): read, then write P; compare against ~P.
- **M3** (descending): read only, 1 cycle/addr.
  - Compare against P one cycle later, pipelined with the next read.
  - After address 0, go to DRAIN.
- **DRAIN**: no access (sram_cen=1). Performs the final compare for address 0, then goes to DONE.
- **DONE**: bist_done=1 and pass-through; stays until reset or the next start.
- Address counter wraps at the end of each element; element transitions occur on the wrap.
- Compare: any bit mismatch sets bist_fail (sticky). The march continues to completion after a failure.
- Element codes: M1=1, M2=2, M3=3. M0 has no reads.

## Timing
- Counting start-sampling edge as cycle 0:
  - M0 occupies cycles 1–64.
  - M1 occupies 65–192.
  - M2 occupies 193–320.
  - M3 occupies 321–384.
  - DRAIN is cycle 385.
  - bist_done=1 from cycle 386.
- bist_busy=1 exactly in cycles 1–385.
- Reset values:
  - state IDLE;
  - bist_busy, bist_done, bist_fail = 0;
  - diag outputs 0;
  - address counter 0;
  - sram_* = func_* (pass-through).
- Reset mid-march aborts immediately. There is no partial done or fail.
- bist_fail may assert in any compare cycle; it is registered and visible the cycle after the compare.
- Functional requests while bist_busy=1 are dropped, not queued.

## Configuration
- AQ_SPSRAM_BIST_DIAG_EN defined:
  - the first mismatch captures bist_fail_addr, bist_fail_elem and bist_fail_syn;
  - the capture is frozen until the next start or reset.
- Undefined: the three diag outputs are constant 0, with no capture registers. The ports still exist.

## Test plan
- Ideal bench memory, pulse start:
  - bist_busy for 385 cycles;
  - bist_done at cycle 386;
  - bist_fail=0.
- Bit 5 stuck-at-1 at address 17, with DIAG_EN:
  - bist_fail=1;
  - fail_addr=17, fail_elem=1, fail_syn=58'h20;
  - done still at cycle 386.
- Pulse start again at cycle 100 of a run: ignored; done still at cycle 386.
- Assert RST at cycle 200: all outputs return to reset values next cycle; sram_* follow func_*.
- Idle pass-through: func_a=5, func_gwen=1, func_d=58'h3, func_cen=0 → identical values on sram_*. A func read of address 5 the next cycle returns 58'h3 on func_q.
- Run with a fault, then start on the fault-free memory: bist_fail cleared at start and stays 0; diag outputs are 0.

Source files
------------

// File: rtl/aq_f_spsram_bist_ctrl.sv
// aq_f_spsram_bist_ctrl
// March-test initiator for a single-port SRAM wrapper. In IDLE/DONE the
// functional requester passes straight through to the SRAM. bist_start
// seizes the port and runs a four-element march:
//   M0 up: w(P)   M1 up: r(P),w(~P)   M2 down: r(~P),w(P)   M3 down: r(P)
// followed by a DRAIN cycle for the final pipelined M3 compare.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   bist_start                single-cycle start request (IDLE/DONE only)
//   bist_busy                 march in progress, BIST owns the SRAM
//   bist_done, bist_fail      sticky completion / mismatch flags
//   bist_fail_addr/elem/syn   first-failure diagnostics
//   func_*                    functional SRAM request; func_q mirrors sram_q
//   sram_*                    SRAM wrapper port (CEN active low, GWEN=1 write,
//                             WEN active-high bit write enable)
//
// Configuration macro: AQ_SPSRAM_BIST_DIAG_EN
//   defined   - first mismatch captures addr/element/syndrome, frozen until
//               the next start or reset
//   undefined - diag outputs tie to 0, no capture registers
module aq_f_spsram_bist_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 58,
    parameter logic [DATA_WIDTH-1:0] BIST_PATTERN = {29{2'b01}}
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bist_start,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_fail,
    output logic [ADDR_WIDTH-1:0] bist_fail_addr,
    output logic [1:0]            bist_fail_elem,
    output logic [DATA_WIDTH-1:0] bist_fail_syn,
    input  logic [ADDR_WIDTH-1:0] func_a,
    input  logic                  func_cen,
    input  logic                  func_gwen,
    input  logic [DATA_WIDTH-1:0] func_wen,
    input  logic [DATA_WIDTH-1:0] func_d,
    output logic [DATA_WIDTH-1:0] func_q,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M0    = 3'd1,
        ST_M1    = 3'd2,
        ST_M2    = 3'd3,
        ST_M3    = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    phase_q, phase_d;      // 0: read, 1: write+compare
    logic                    m3_pend_q, m3_pend_d;  // an M3 read awaits compare
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;

    logic                    start_acc;
    logic                    cmp_en;
    logic [DATA_WIDTH-1:0]   cmp_exp;
    logic [DATA_WIDTH-1:0]   cmp_syn;
    logic                    mismatch;

    // Next-state, address sequencing and compare
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        m3_pend_d = m3_pend_q;
        busy_d    = busy_q;
        done_d    = done_q;
        fail_d    = fail_q;
        start_acc = 1'b0;
        cmp_en    = 1'b0;
        cmp_exp   = BIST_PATTERN;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_M0;
                    addr_d    = '0;
                    phase_d   = 1'b0;
                    m3_pend_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                end
            end
            ST_M0: begin
                addr_d = addr_q + ADDR_ONE;
                if (addr_q == ADDR_MAX) begin
                    state_d = ST_M1;
                end
            end
            ST_M1: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    cmp_en = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    if (addr_q == ADDR_MAX) begin
                        // descending element starts from the top
                        state_d = ST_M2;
                        addr_d  = ADDR_MAX;
                    end
                end
            end
            ST_M2: begin
                phase_d = ~phase_q;
                cmp_exp = ~BIST_PATTERN;
                if (phase_q) begin
                    cmp_en = 1'b1;
                    addr_d = addr_q - ADDR_ONE;
                    if (addr_q == '0) begin
                        state_d = ST_M3;
                    end
                end
            end
            ST_M3: begin
                // compare the previous cycle's read while issuing the next
                cmp_en    = m3_pend_q;
                m3_pend_d = 1'b1;
                addr_d    = addr_q - ADDR_ONE;
                if (addr_q == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cmp_en    = m3_pend_q;
                m3_pend_d = 1'b0;
                addr_d    = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmp_syn  = sram_q ^ cmp_exp;
        mismatch = cmp_en && (cmp_syn != '0);
        if (mismatch) begin
            fail_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            m3_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            m3_pend_q <= m3_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    // SRAM port: pass-through when idle/done, march access otherwise
    always_comb begin
        sram_a    = func_a;
        sram_cen  = func_cen;
        sram_gwen = func_gwen;
        sram_wen  = func_wen;
        sram_d    = func_d;
        if (state_q != ST_IDLE && state_q != ST_DONE) begin
            sram_a    = addr_q;
            sram_cen  = (state_q == ST_DRAIN);
            sram_wen  = '1;
            sram_gwen = 1'b0;
            sram_d    = BIST_PATTERN;
            case (state_q)
                ST_M0: sram_gwen = 1'b1;
                ST_M1: begin
                    sram_gwen = phase_q;
                    sram_d    = ~BIST_PATTERN;
                end
                ST_M2: sram_gwen = phase_q;
                default: sram_gwen = 1'b0;
            endcase
        end
    end

    assign func_q    = sram_q;
    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign bist_fail = fail_q;

`ifdef AQ_SPSRAM_BIST_DIAG_EN
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [1:0]            fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_syn_q, fail_syn_d;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [1:0]            cmp_elem;

    // First-failure capture; M3 compares lag the read address by one step
    always_comb begin
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_syn_d  = fail_syn_q;
        cmp_addr    = addr_q;
        cmp_elem    = 2'd0;
        case (state_q)
            ST_M1:    cmp_elem = 2'd1;
            ST_M2:    cmp_elem = 2'd2;
            ST_M3: begin
                cmp_elem = 2'd3;
                cmp_addr = addr_q + ADDR_ONE;
            end
            ST_DRAIN: begin
                cmp_elem = 2'd3;
                cmp_addr = '0;
            end
            default:  cmp_elem = 2'd0;
        endcase
        if (start_acc) begin
            fail_addr_d = '0;
            fail_elem_d = 2'd0;
            fail_syn_d  = '0;
        end else if (mismatch && !fail_q) begin
            fail_addr_d = cmp_addr;
            fail_elem_d = cmp_elem;
            fail_syn_d  = cmp_syn;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fail_addr_q <= '0;
            fail_elem_q <= 2'd0;
            fail_syn_q  <= '0;
        end else begin
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_syn_q  <= fail_syn_d;
        end
    end

    assign bist_fail_addr = fail_addr_q;
    assign bist_fail_elem = fail_elem_q;
    assign bist_fail_syn  = fail_syn_q;
`else
    assign bist_fail_addr = '0;
    assign bist_fail_elem = 2'd0;
    assign bist_fail_syn  = '0;
`endif

endmodule

// File: tb/tb_aq_f_spsram_bist_ctrl.sv
// Bench for aq_f_spsram_bist_ctrl: behavioural 64x58 SRAM with an optional
// stuck-at-1 cell, scoreboard of expected end-of-march results checked by a
// monitor on the rising edge of bist_done.
module tb_aq_f_spsram_bist_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 58;
    localparam logic [DW-1:0] P = {29{2'b01}};

    typedef struct packed {
        logic          fail;
        logic [AW-1:0] addr;
        logic [1:0]    elem;
        logic [DW-1:0] syn;
    } exp_t;

    logic          CLK, RST, bist_start;
    logic          bist_busy, bist_done, bist_fail;
    logic [AW-1:0] bist_fail_addr;
    logic [1:0]    bist_fail_elem;
    logic [DW-1:0] bist_fail_syn;
    logic [AW-1:0] func_a, sram_a;
    logic          func_cen, func_gwen, sram_cen, sram_gwen;
    logic [DW-1:0] func_wen, func_d, func_q, sram_wen, sram_d, sram_q;

    aq_f_spsram_bist_ctrl dut (
        .CLK(CLK), .RST(RST), .bist_start(bist_start),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
        .bist_fail_addr(bist_fail_addr), .bist_fail_elem(bist_fail_elem),
        .bist_fail_syn(bist_fail_syn),
        .func_a(func_a), .func_cen(func_cen), .func_gwen(func_gwen),
        .func_wen(func_wen), .func_d(func_d), .func_q(func_q),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // SRAM model; fault_en makes bit 5 of address 17 read as 1
    logic [DW-1:0] mem [64];
    logic          fault_en;
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        sram_q = '0;
    end
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
            end else begin
                sram_q <= mem[sram_a] |
                          ((fault_en && sram_a == 6'd17) ? 58'h20 : 58'h0);
            end
        end
    end

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   run_k;
    int   busy_cnt;
    logic run_active;
    logic done_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: cycle-count the run, pop and compare when bist_done rises
    always @(negedge CLK) begin
        if (run_active) begin
            run_k++;
            if (bist_busy) busy_cnt++;
            if (run_k == 1) begin
                chk("busy_at_cycle1", 64'(bist_busy), 64'd1);
                chk("cleared_at_start",
                    64'({bist_fail, bist_fail_addr, bist_fail_elem} | (bist_fail_syn != '0)),
                    64'd0);
            end
            if (bist_done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(run_k), 64'd386);
                    chk("busy_cycles", 64'(busy_cnt), 64'd385);
                    chk("fail", 64'(bist_fail), 64'(e.fail));
                    chk("fail_addr", 64'(bist_fail_addr), 64'(e.addr));
                    chk("fail_elem", 64'(bist_fail_elem), 64'(e.elem));
                    chk("fail_syn", 64'(bist_fail_syn), 64'(e.syn));
                end
            end
        end
        done_prev = bist_done;
    end

    task automatic kick();
        @(posedge CLK); #1;
        bist_start = 1'b1;
        busy_cnt   = 0;
        run_k      = -1;
        run_active = 1'b1;
        @(posedge CLK); #1;
        bist_start = 1'b0;
    endtask

    task automatic run_bist(input exp_t e, input int restart_at);
        exp_q.push_back(e);
        kick();
        if (restart_at > 0) begin
            wait (run_k == restart_at);
            bist_start = 1'b1;
            @(negedge CLK);
            bist_start = 1'b0;
        end
        for (int i = 0; i < 450 && exp_q.size() != 0; i++) @(negedge CLK);
        chk("run_completed", 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        run_active = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        exp_t clean, faulty;
        clean  = '{fail: 1'b0, addr: '0, elem: 2'd0, syn: '0};
`ifdef AQ_SPSRAM_BIST_DIAG_EN
        faulty = '{fail: 1'b1, addr: 6'd17, elem: 2'd1, syn: 58'h20};
`else
        faulty = '{fail: 1'b1, addr: '0, elem: 2'd0, syn: '0};
`endif
        RST = 1'b1; bist_start = 1'b0; fault_en = 1'b0;
        run_active = 1'b0; run_k = 0; busy_cnt = 0;
        func_a = 6'd9; func_cen = 1'b1; func_gwen = 1'b0;
        func_wen = '1; func_d = 58'h155;

        // Reset state and pass-through under reset
        repeat (3) @(negedge CLK);
        chk("rst_busy_done_fail", 64'({bist_busy, bist_done, bist_fail}), 64'd0);
        chk("rst_diag", 64'({bist_fail_addr, bist_fail_elem}) | 64'(bist_fail_syn != '0), 64'd0);
        chk("rst_pass_a", 64'(sram_a), 64'd9);
        chk("rst_pass_d", 64'(sram_d), 64'h155);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Idle pass-through write then read of address 5
        @(posedge CLK); #1;
        func_a = 6'd5; func_gwen = 1'b1; func_d = 58'h3; func_cen = 1'b0;
        #1;
        chk("pt_a", 64'(sram_a), 64'd5);
        chk("pt_cen_gwen", 64'({sram_cen, sram_gwen}), 64'b01);
        chk("pt_d", 64'(sram_d), 64'h3);
        chk("pt_wen", 64'(sram_wen), 64'(58'h3ff_ffff_ffff_ffff));
        @(posedge CLK); #1;
        func_gwen = 1'b0;
        @(posedge CLK); #1;
        chk("pt_read_q", 64'(func_q), 64'h3);
        func_cen = 1'b1;

        // Fault-free march
        run_bist(clean, 0);
        // Stuck-at-1 bit 5 at address 17
        fault_en = 1'b1;
        run_bist(faulty, 0);
        fault_en = 1'b0;
        // Restart on good memory clears the previous failure
        run_bist(clean, 0);
        // Start at cycle 100 ignored; functional writes during busy dropped
        func_a = 6'd17; func_d = '0; func_gwen = 1'b1; func_cen = 1'b0;
        run_bist(clean, 100);
        func_cen = 1'b1; func_gwen = 1'b0;

        // Reset at cycle 200 aborts the march
        func_a = 6'd33; func_d = 58'h2a; func_cen = 1'b1;
        kick();
        wait (run_k == 200);
        chk("busy_mid_run", 64'(bist_busy), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_flags", 64'({bist_busy, bist_done, bist_fail}), 64'd0);
        chk("abort_pass_a", 64'(sram_a), 64'd33);
        chk("abort_pass_cen", 64'(sram_cen), 64'd1);
        chk("abort_pass_d", 64'(sram_d), 64'h2a);
        run_active = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("post_abort_idle", 64'({bist_busy, bist_done}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
